// File: rtl/regfile_sb.sv
// Parametrised 2-read/1-write register file with a per-register busy scoreboard,
// same-cycle write-to-read bypass and a sticky unexpected-writeback flag.
module regfile_sb #(
  parameter int unsigned DATA_W   = 21,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd0_addr,
  output logic [DATA_W-1:0]        rd0_data,
  output logic                     rd0_busy,
  input  logic [ADDR_W-1:0]        rd1_addr,
  output logic [DATA_W-1:0]        rd1_data,
  output logic                     rd1_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic                     wb_err
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wb_err_q, wb_err_d;

  logic wr_ok, rsv_ok;
  logic rd0_zero, rd1_zero, rd0_fwd, rd1_fwd;

  // Register 0 swallows writes and reservations when it is hardwired to zero.
  assign wr_ok  = wr_en  && !(ZERO_REG && (wr_addr  == '0));
  assign rsv_ok = rsv_en && !(ZERO_REG && (rsv_addr == '0));

  always_comb begin
    mem_d    = mem_q;
    busy_d   = flush ? '0 : busy_q;
    wb_err_d = wb_err_q;
    if (wr_ok) begin
      mem_d[wr_addr]  = wr_data;
      busy_d[wr_addr] = 1'b0;
      if (!busy_q[wr_addr]) wb_err_d = 1'b1;
    end
    // Reservation is applied last so it beats both flush and a same-address writeback.
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign rd0_zero = ZERO_REG && (rd0_addr == '0);
  assign rd1_zero = ZERO_REG && (rd1_addr == '0);
  assign rd0_fwd  = BYPASS && wr_en && (wr_addr == rd0_addr);
  assign rd1_fwd  = BYPASS && wr_en && (wr_addr == rd1_addr);

  // The zero register overrides the bypass path on both data and busy.
  assign rd0_data = rd0_zero ? '0 : (rd0_fwd ? wr_data : mem_q[rd0_addr]);
  assign rd1_data = rd1_zero ? '0 : (rd1_fwd ? wr_data : mem_q[rd1_addr]);
  assign rd0_busy = !rd0_zero && !rd0_fwd && busy_q[rd0_addr];
  assign rd1_busy = !rd1_zero && !rd1_fwd && busy_q[rd1_addr];

  assign busy   = busy_q;
  assign wb_err = wb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one instance with defaults and one with ZERO_REG=1,
// both driven by identical stimulus and compared against a reference model.
module tb_regfile_sb;

  logic        clk, rst;
  logic        wr_en, rsv_en, flush;
  logic [2:0]  wr_addr, rsv_addr, rd0_addr, rd1_addr;
  logic [20:0] wr_data;

  logic [20:0] rd0_data_a, rd1_data_a, rd0_data_z, rd1_data_z;
  logic        rd0_busy_a, rd1_busy_a, rd0_busy_z, rd1_busy_z;
  logic [7:0]  busy_a, busy_z;
  logic        wb_err_a, wb_err_z;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: index 0 = default instance, 1 = ZERO_REG instance
  logic [20:0] m_mem [2][8];
  logic [7:0]  m_busy [2];
  logic        m_err [2];

  typedef struct {
    logic        we;  logic [2:0] wa; logic [20:0] wd;
    logic        re;  logic [2:0] ra; logic        fl;
    logic [2:0]  r0;  logic [2:0] r1;
    logic [20:0] e_d0; logic [20:0] e_d1;
    logic        e_b0; logic        e_b1;
    logic [7:0]  e_busy; logic      e_err;
  } vec_t;

  vec_t tbl [15];

  regfile_sb u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_addr(rd0_addr), .rd0_data(rd0_data_a), .rd0_busy(rd0_busy_a),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data_a), .rd1_busy(rd1_busy_a),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .busy(busy_a), .wb_err(wb_err_a)
  );

  regfile_sb #(.ZERO_REG(1'b1)) u_z (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_addr(rd0_addr), .rd0_data(rd0_data_z), .rd0_busy(rd0_busy_z),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data_z), .rd1_busy(rd1_busy_z),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .busy(busy_z), .wb_err(wb_err_z)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic we, logic [2:0] wa, logic [20:0] wd, logic re,
                              logic [2:0] ra, logic fl, logic [2:0] r0, logic [2:0] r1,
                              logic [20:0] d0, logic [20:0] d1, logic b0, logic b1,
                              logic [7:0] bz, logic er);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.fl = fl;
    v.r0 = r0; v.r1 = r1; v.e_d0 = d0; v.e_d1 = d1; v.e_b0 = b0; v.e_b1 = b1;
    v.e_busy = bz; v.e_err = er;
    return v;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 8; i++) m_mem[z][i] = '0;
      m_busy[z] = '0;
      m_err[z]  = 1'b0;
    end
  endtask

  function automatic logic [20:0] m_rd(int z, logic [2:0] a);
    if (z == 1 && a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[z][a];
  endfunction

  function automatic logic m_rb(int z, logic [2:0] a);
    if (z == 1 && a == 0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_busy[z][a];
  endfunction

  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      automatic bit w_ok = wr_en && !(z == 1 && wr_addr == 0);
      automatic bit r_ok = rsv_en && !(z == 1 && rsv_addr == 0);
      automatic logic [7:0] nb = flush ? 8'h00 : m_busy[z];
      if (w_ok && !m_busy[z][wr_addr]) m_err[z] = 1'b1;
      if (w_ok) begin
        m_mem[z][wr_addr] = wr_data;
        nb[wr_addr] = 1'b0;
      end
      if (r_ok) nb[rsv_addr] = 1'b1;
      m_busy[z] = nb;
    end
  endtask

  task automatic check_comb_model();
    check("a_rd0_data", rd0_data_a, m_rd(0, rd0_addr));
    check("a_rd1_data", rd1_data_a, m_rd(0, rd1_addr));
    check("a_rd0_busy", rd0_busy_a, m_rb(0, rd0_addr));
    check("a_rd1_busy", rd1_busy_a, m_rb(0, rd1_addr));
    check("z_rd0_data", rd0_data_z, m_rd(1, rd0_addr));
    check("z_rd1_data", rd1_data_z, m_rd(1, rd1_addr));
    check("z_rd0_busy", rd0_busy_z, m_rb(1, rd0_addr));
    check("z_rd1_busy", rd1_busy_z, m_rb(1, rd1_addr));
  endtask

  task automatic check_state_model();
    check("a_busy",   busy_a,   m_busy[0]);
    check("a_wb_err", wb_err_a, m_err[0]);
    check("z_busy",   busy_z,   m_busy[1]);
    check("z_wb_err", wb_err_z, m_err[1]);
  endtask

  // ---------------- driver ----------------
  task automatic drive(logic we, logic [2:0] wa, logic [20:0] wd, logic re,
                       logic [2:0] ra, logic fl, logic [2:0] r0, logic [2:0] r1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra; flush = fl;
    rd0_addr = r0; rd1_addr = r1;
  endtask

  // inputs are driven 1 time unit after a rising edge; this samples mid-cycle, then across the edge
  task automatic cycle_checks();
    #4;
    check_comb_model();
    @(posedge clk);
    #1;
    model_edge();
    check_state_model();
  endtask

  task automatic reset_pulse();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    model_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 21'h0,      1, 2, 0, 2, 0, 21'h0,      21'h0,      0, 0, 8'h04, 0);
    tbl[1]  = mk(0, 0, 21'h0,      0, 0, 0, 2, 5, 21'h0,      21'h0,      1, 0, 8'h04, 0);
    tbl[2]  = mk(1, 2, 21'h155555, 0, 0, 0, 2, 2, 21'h155555, 21'h155555, 0, 0, 8'h00, 0);
    tbl[3]  = mk(0, 0, 21'h0,      1, 5, 0, 2, 5, 21'h155555, 21'h0,      0, 0, 8'h20, 0);
    tbl[4]  = mk(1, 5, 21'h0F0F0,  0, 0, 0, 5, 5, 21'h0F0F0,  21'h0F0F0,  0, 0, 8'h00, 0);
    tbl[5]  = mk(0, 0, 21'h0,      1, 6, 0, 2, 5, 21'h155555, 21'h0F0F0,  0, 0, 8'h40, 0);
    tbl[6]  = mk(1, 6, 21'h000777, 1, 6, 0, 6, 5, 21'h000777, 21'h0F0F0,  0, 0, 8'h40, 0);
    tbl[7]  = mk(1, 4, 21'h000ABC, 0, 0, 0, 6, 4, 21'h000777, 21'h000ABC, 1, 0, 8'h40, 1);
    tbl[8]  = mk(0, 0, 21'h0,      0, 0, 0, 4, 6, 21'h000ABC, 21'h000777, 0, 1, 8'h40, 1);
    tbl[9]  = mk(0, 0, 21'h0,      1, 1, 0, 1, 7, 21'h0,      21'h0,      0, 0, 8'h42, 1);
    tbl[10] = mk(0, 0, 21'h0,      1, 7, 0, 1, 7, 21'h0,      21'h0,      1, 0, 8'hC2, 1);
    tbl[11] = mk(0, 0, 21'h0,      1, 3, 1, 7, 1, 21'h0,      21'h0,      1, 1, 8'h08, 1);
    tbl[12] = mk(1, 3, 21'h12345,  0, 0, 1, 3, 6, 21'h12345,  21'h000777, 0, 0, 8'h00, 1);
    tbl[13] = mk(0, 0, 21'h0,      0, 0, 0, 3, 3, 21'h12345,  21'h12345,  0, 0, 8'h00, 1);
    tbl[14] = mk(1, 0, 21'h1FFFFF, 1, 0, 0, 0, 2, 21'h1FFFFF, 21'h155555, 0, 0, 8'h01, 1);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // asynchronous reset wipes a committed write without waiting for an edge
    drive(1, 3, 21'h1ABCDE, 0, 0, 0, 3, 3);
    cycle_checks();
    drive(0, 0, 0, 0, 0, 0, 3, 3);
    #2;
    check("pre_rst_rd0", rd0_data_a, 32'h1ABCDE);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_rd0_data", rd0_data_a, 32'h0);
    check("rst_rd0_busy", rd0_busy_a, 32'h0);
    check("rst_busy",     busy_a,     32'h0);
    check("rst_wb_err",   wb_err_a,   32'h0);
    check("rst_z_wb_err", wb_err_z,   32'h0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // hardwired zero register ignores write and reservation
    drive(1, 0, 21'h1FFFFF, 1, 0, 0, 0, 0);
    #4;
    check("z0_rd0_data", rd0_data_z, 32'h0);
    check("z0_rd0_busy", rd0_busy_z, 32'h0);
    check("z0_rd1_data", rd1_data_z, 32'h0);
    check_comb_model();
    @(posedge clk);
    #1;
    model_edge();
    check("z0_busy0",  busy_z[0], 32'h0);
    check("z0_wb_err", wb_err_z,  32'h0);
    check_state_model();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    check("z0_rd_after", rd0_data_z, 32'h0);
    @(posedge clk);
    #1;
    model_edge();
    reset_pulse();

    // directed table on the default instance
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].fl, tbl[i].r0, tbl[i].r1);
      #4;
      check($sformatf("t%0d_rd0_data", i), rd0_data_a, tbl[i].e_d0);
      check($sformatf("t%0d_rd1_data", i), rd1_data_a, tbl[i].e_d1);
      check($sformatf("t%0d_rd0_busy", i), rd0_busy_a, tbl[i].e_b0);
      check($sformatf("t%0d_rd1_busy", i), rd1_busy_a, tbl[i].e_b1);
      check_comb_model();
      @(posedge clk);
      #1;
      model_edge();
      check($sformatf("t%0d_busy", i),   busy_a,   tbl[i].e_busy);
      check($sformatf("t%0d_wb_err", i), wb_err_a, tbl[i].e_err);
      check_state_model();
    end

    // randomized traffic against the model, with occasional resets
    for (int n = 0; n < 400; n++) begin
      if (n == 200) reset_pulse();
      drive($urandom_range(0, 1), 3'($urandom_range(0, 7)), 21'($urandom),
            ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      cycle_checks();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
